// File: rtl/opd_forward_ctrl.sv
// Operand forwarding and load-use hazard control between register read and EX.
// Youngest matching producer wins; a not-ready match blocks the source and stalls decode.
module opd_forward_ctrl #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned STALL_MAX = 15,
    parameter int unsigned WB_SHADOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_vld,
    input  logic [NUM_SRC*5-1:0]    src_addr,
    input  logic [NUM_SRC*XLEN-1:0] src_rddata,
    input  logic [DEPTH-1:0]        stg_vld,
    input  logic [DEPTH*5-1:0]      stg_rd,
    input  logic [DEPTH-1:0]        stg_rdy,
    input  logic [DEPTH*XLEN-1:0]   stg_data,
    input  logic                    wb_we,
    input  logic [4:0]              wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    output logic [NUM_SRC*XLEN-1:0] OF_x_rs,
    output logic [NUM_SRC-1:0]      OF_fwd_hit,
    output logic                    OF_stall,
    output logic                    OF_stall_timeout,
    output logic [31:0]             OF_stall_cnt
);

    localparam int unsigned LW = $clog2(STALL_MAX + 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    logic                    w_shd_vld;
    logic [4:0]              w_shd_rd;
    logic [XLEN-1:0]         w_shd_data;
    logic [NUM_SRC*XLEN-1:0] w_x_rs;
    logic [NUM_SRC-1:0]      w_hit;
    logic [NUM_SRC-1:0]      w_blk;
    logic                    w_stall;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LW-1:0]           r_len;
    logic [LW-1:0]           w_len_nxt;
    logic                    r_timeout;
    logic [31:0]             r_cnt;

    // Write-back shadow covers the cycle where the regfile read still returns stale data.
    generate
        if (WB_SHADOW != 0) begin : g_shadow
            logic            r_shd_vld;
            logic [4:0]      r_shd_rd;
            logic [XLEN-1:0] r_shd_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_shd_vld  <= 1'b0;
                    r_shd_rd   <= '0;
                    r_shd_data <= '0;
                end else begin
                    r_shd_vld  <= wb_we & (wb_rd != 5'd0);
                    r_shd_rd   <= wb_rd;
                    r_shd_data <= wb_data;
                end
            end

            assign w_shd_vld  = r_shd_vld;
            assign w_shd_rd   = r_shd_rd;
            assign w_shd_data = r_shd_data;
        end else begin : g_no_shadow
            assign w_shd_vld  = 1'b0;
            assign w_shd_rd   = '0;
            assign w_shd_data = '0;
        end
    endgenerate

    always_comb begin
        logic       v_found;
        logic [4:0] v_addr;
        w_x_rs  = '0;
        w_hit   = '0;
        w_blk   = '0;
        v_found = 1'b0;
        v_addr  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            v_addr  = src_addr[i*5 +: 5];
            v_found = 1'b0;
            w_x_rs[i*XLEN +: XLEN] = src_rddata[i*XLEN +: XLEN];
            if (v_addr != 5'd0) begin
                // First match stops the search even when not ready: older data is stale.
                for (int unsigned j = 0; j < DEPTH; j++) begin
                    if (!v_found && stg_vld[j] && (stg_rd[j*5 +: 5] == v_addr)) begin
                        v_found = 1'b1;
                        if (stg_rdy[j]) begin
                            w_x_rs[i*XLEN +: XLEN] = stg_data[j*XLEN +: XLEN];
                            w_hit[i]               = 1'b1;
                        end else begin
                            w_blk[i] = 1'b1;
                        end
                    end
                end
                if (!v_found && w_shd_vld && (w_shd_rd == v_addr)) begin
                    w_x_rs[i*XLEN +: XLEN] = w_shd_data;
                    w_hit[i]               = 1'b1;
                end
            end
        end
    end

    assign w_stall = id_vld & (|w_blk);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_stall)  w_state_nxt = S_STALL;
            S_STALL: if (!w_stall) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_len_nxt = '0;
        case (r_state)
            S_IDLE: begin
                if (w_stall) w_len_nxt = LW'(1);
            end
            S_STALL: begin
                if (w_stall) begin
                    w_len_nxt = (r_len >= LW'(STALL_MAX)) ? LW'(STALL_MAX) : r_len + LW'(1);
                end
            end
            default: w_len_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_len     <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_len <= w_len_nxt;
            if (w_len_nxt == LW'(STALL_MAX)) begin
                r_timeout <= 1'b1;
            end
            if (w_stall) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

    assign OF_x_rs          = w_x_rs;
    assign OF_fwd_hit       = w_hit;
    assign OF_stall         = w_stall;
    assign OF_stall_timeout = r_timeout;
    assign OF_stall_cnt     = r_cnt;

endmodule

// File: doc/opd_forward_ctrl.md
Name: opd_forward_ctrl

Overview:
- Parametrised operand-forwarding and hazard controller between REGS read and the EX stage.
- Generalises single-stage EX forwarding to:
  - DEPTH producer stages with youngest-first priority;
  - NUM_SRC independent source operands;
  - x0 suppression;
  - a registered write-back shadow for the synchronous register file;
  - load-use stall generation with a stall FSM, timeout flag and performance counter.

Parameters:
- XLEN, 32, operand/result width.
- DEPTH, 3, producer stages tracked; index 0 = youngest (EX), DEPTH-1 = oldest (WB-1).
- NUM_SRC, 2, source operands per instruction.
- STALL_MAX, 15, stall cycles after which the timeout flag sets; minimum 1.
- WB_SHADOW, 1, 1 = forward last write-back for one cycle after the regfile write.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_vld  in  1  decode holds a valid instruction that reads operands this cycle.
- src_addr  in  NUM_SRC*5  source register indices; slice i = source i.
- src_rddata  in  NUM_SRC*XLEN  REGS read data per source.
- stg_vld  in  DEPTH  stage j holds an instruction that writes rd.
- stg_rd  in  DEPTH*5  destination index per stage.
- stg_rdy  in  DEPTH  stage j result is available (0 = load data not yet returned).
- stg_data  in  DEPTH*XLEN  result per stage; ignored when stg_rdy[j]=0.
- wb_we  in  1  regfile write strobe this cycle.
- wb_rd  in  5  regfile write index.
- wb_data  in  XLEN  regfile write data.
- OF_x_rs  out  NUM_SRC*XLEN  resolved operands.
- OF_fwd_hit  out  NUM_SRC  per-source forward taken (any stage or shadow).
- OF_stall  out  1  hold decode/fetch, insert bubble in EX.
- OF_stall_timeout  out  1  sticky: a stall reached STALL_MAX cycles.
- OF_stall_cnt  out  32  total stall cycles since reset, wraps.

Behaviour:
- Per source i, combinational, independent of other sources.
  - Match j: stg_vld[j] & stg_rd[j]==src_addr[i] & src_addr[i]!=0.
  - Select the lowest-index matching j (youngest wins).
  - If selected j has stg_rdy[j]=1: OF_x_rs[i]=stg_data[j], OF_fwd_hit[i]=1.
  - If selected j has stg_rdy[j]=0: source i is blocked; OF_x_rs[i]=src_rddata[i]; do not fall through to older stages.
  - No stage match, WB_SHADOW=1, shd_vld, shd_rd==src_addr[i], src_addr[i]!=0: OF_x_rs[i]=shd_data, hit=1.
  - Otherwise: OF_x_rs[i]=src_rddata[i], hit=0.
  - src_addr[i]==0: always src_rddata[i], never a hit, never blocked.
- OF_stall = id_vld & (any source blocked). Combinational, same cycle.
- Shadow register (WB_SHADOW=1):
  - Each cycle: shd_vld<=wb_we & wb_rd!=0; shd_rd<=wb_rd; shd_data<=wb_data.
  - Valid exactly one cycle after the write.
  - Reset: shd_vld=0, shd_rd=0, shd_data=0.
- Stall FSM, states IDLE and STALL, with stall_len counter (saturating at STALL_MAX):
  - IDLE: OF_stall -> STALL, stall_len<=1; else stay.
  - STALL: OF_stall -> stall_len<=min(stall_len+1, STALL_MAX); !OF_stall -> IDLE, stall_len<=0.
  - OF_stall_timeout sets on the first cycle stall_len==STALL_MAX and holds until rst.
  - OF_stall_cnt increments on every cycle OF_stall=1, wrapping 0xFFFFFFFF->0.
- Reset values:
  - state=IDLE, stall_len=0, OF_stall_timeout=0, OF_stall_cnt=0, shadow cleared.
  - Combinational outputs follow their inputs during reset; shadow forwarding is disabled because shd_vld=0.
- Reset mid-stall: next cycle state=IDLE, counters 0, timeout cleared. OF_stall still follows its inputs.
- Simultaneous conditions:
  - Two sources matching different stages resolve independently.
  - Both sources naming the same register get the same value.
  - A stage match with wb_we to the same rd in the same cycle: the stage wins.

Test Plan:
- EX priority: stg0 rd=5 data=0xAAAA, stg2 rd=5 data=0xBBBB, both rdy, src0=5 -> OF_x_rs[0]=0xAAAA, hit[0]=1, no stall.
- Dual source: stg0 rd=3 data=0x11, stg1 rd=4 data=0x22, src0=3, src1=4 -> 0x11 and 0x22, hit=2'b11. Checks the case where rs1 forwarding must not suppress rs2.
- x0 suppression: stg0 rd=0 data=0xDEAD, src0=0, src_rddata0=0 -> output 0, hit=0, no stall.
- Load-use:
  - stg0 rd=7 rdy=0, stg1 rd=7 rdy=1, id_vld=1, src1=7 -> OF_stall=1, old stg1 value not used.
  - 3 cycles later rdy=1 -> stall drops; OF_stall_cnt=3; FSM back to IDLE.
- Shadow: wb_we=1 rd=9 data=0x1234 at cycle n, no stage match at n+1, src0=9, src_rddata0 stale -> 0x1234 at n+1; at n+2 -> src_rddata0.
- Timeout/reset: STALL_MAX=4, hold blocked 6 cycles -> timeout rises on 4th stall cycle and stays; rst pulse -> timeout=0, cnt=0, state IDLE.
